// File: rtl/ga_pkg.sv
// Shared definitions for the genetic-algorithm datapath blocks.
// Holds genome/family geometry, the LFSR polynomial and default seed,
// the generation-controller state encoding and the family slicing helper.
package ga_pkg;

    localparam int GENOME_W = 150;
    localparam int FAMILY_N = 5;
    localparam int FAMILY_W = GENOME_W * FAMILY_N;

    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] SEED_INIT_DEFAULT = 32'hACE1_2F5B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_WAIT,
        ST_OFFER,
        ST_SCORE,
        ST_UPDATE,
        ST_FINISH
    } gc_state_e;

    // Genome i sits at bits [GENOME_W*(FAMILY_N-i)-1 -: GENOME_W], so index 0
    // is the most significant slice. Out-of-range indices fall back to 0.
    function automatic logic [GENOME_W-1:0] family_slice(
        input logic [FAMILY_W-1:0] fam,
        input logic [2:0]          idx
    );
        logic [GENOME_W-1:0] g;
        g = fam[FAMILY_W-1 -: GENOME_W];
        for (int i = 1; i < FAMILY_N; i++) begin
            if (idx == 3'(i)) begin
                g = fam[GENOME_W*(FAMILY_N-i)-1 -: GENOME_W];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ga_lfsr32.sv
// 32-bit Galois LFSR (right shift) that never holds the all-zero state.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   step      - advance one position on the next rising edge
//   seed      - current register value
module ga_lfsr32
    import ga_pkg::*;
#(
    parameter logic [31:0] SEED_INIT = SEED_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [31:0] seed
);

    // A zero seed would lock the register, so substitute the default.
    localparam logic [31:0] SEED_SAFE =
        (SEED_INIT == 32'h0) ? SEED_INIT_DEFAULT : SEED_INIT;

    logic [31:0] seed_q;
    logic [31:0] seed_d;
    logic [31:0] shifted;

    always_comb begin
        shifted = {1'b0, seed_q[31:1]} ^ (seed_q[0] ? LFSR_POLY : 32'h0);
        seed_d  = seed_q;
        if (step) begin
            seed_d = (shifted == 32'h0) ? SEED_SAFE : shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q <= SEED_SAFE;
        end else begin
            seed_q <= seed_d;
        end
    end

    assign seed = seed_q;

endmodule

// File: rtl/generation_controller.sv
// Sequences GA generations: steps the seed, waits for the mutation stage,
// offers the captured family to the evaluator, adopts the winner as the next
// parent and tracks the best genome of the run.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   start, init_parent, max_gen     - run request and its latched arguments
//   prg_seed, parent                - drive the mutation stage
//   family                          - mutation-stage output (genome 0 = parent)
//   eval_valid/eval_ready/eval_family - family handoff to the evaluator
//   score_valid, best_idx, best_score - evaluator result strobe
//   busy, done, gen_count           - run status
//   elite_genome, elite_score       - best result of the run
//
// state   | meaning
// IDLE    | waiting for start
// STEP    | seed advances on the exit edge
// WAIT    | mutation latency countdown, family captured at zero
// OFFER   | eval_valid high until eval_ready
// SCORE   | waiting for score_valid
// UPDATE  | adopt winner, update elite, count generation
// FINISH  | one-cycle done pulse
module generation_controller
    import ga_pkg::*;
#(
    parameter int unsigned MUT_LAT   = 1,
    parameter logic [31:0] SEED_INIT = SEED_INIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [GENOME_W-1:0] init_parent,
    input  logic [15:0]         max_gen,
    output logic [31:0]         prg_seed,
    output logic [GENOME_W-1:0] parent,
    input  logic [FAMILY_W-1:0] family,
    output logic                eval_valid,
    input  logic                eval_ready,
    output logic [FAMILY_W-1:0] eval_family,
    input  logic                score_valid,
    input  logic [2:0]          best_idx,
    input  logic [15:0]         best_score,
    output logic                busy,
    output logic                done,
    output logic [15:0]         gen_count,
    output logic [GENOME_W-1:0] elite_genome,
    output logic [15:0]         elite_score
);

    localparam logic [15:0] WAIT_LOAD = 16'(MUT_LAT - 1);

    gc_state_e           state_q, state_d;
    logic [GENOME_W-1:0] parent_q, parent_d;
    logic [15:0]         max_gen_q, max_gen_d;
    logic [15:0]         gen_count_q, gen_count_d;
    logic [GENOME_W-1:0] elite_genome_q, elite_genome_d;
    logic [15:0]         elite_score_q, elite_score_d;
    logic [FAMILY_W-1:0] eval_family_q, eval_family_d;
    logic                eval_valid_q, eval_valid_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic [2:0]          win_idx_q, win_idx_d;
    logic [15:0]         win_score_q, win_score_d;

    logic [15:0]         gen_count_inc;
    logic [GENOME_W-1:0] winner;
    logic                lfsr_step;

    assign gen_count_inc = gen_count_q + 16'd1;
    assign winner        = family_slice(eval_family_q, win_idx_q);

    ga_lfsr32 #(.SEED_INIT(SEED_INIT)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (lfsr_step),
        .seed (prg_seed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            parent_q       <= '0;
            max_gen_q      <= '0;
            gen_count_q    <= '0;
            elite_genome_q <= '0;
            elite_score_q  <= '0;
            eval_family_q  <= '0;
            eval_valid_q   <= 1'b0;
            wait_cnt_q     <= '0;
            win_idx_q      <= '0;
            win_score_q    <= '0;
        end else begin
            state_q        <= state_d;
            parent_q       <= parent_d;
            max_gen_q      <= max_gen_d;
            gen_count_q    <= gen_count_d;
            elite_genome_q <= elite_genome_d;
            elite_score_q  <= elite_score_d;
            eval_family_q  <= eval_family_d;
            eval_valid_q   <= eval_valid_d;
            wait_cnt_q     <= wait_cnt_d;
            win_idx_q      <= win_idx_d;
            win_score_q    <= win_score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = (max_gen == 16'd0) ? ST_FINISH : ST_STEP;
            ST_STEP:   state_d = ST_WAIT;
            ST_WAIT:   if (wait_cnt_q == 16'd0) state_d = ST_OFFER;
            ST_OFFER:  if (eval_ready) state_d = ST_SCORE;
            ST_SCORE:  if (score_valid) state_d = ST_UPDATE;
            ST_UPDATE: state_d = (gen_count_inc == max_gen_q) ? ST_FINISH : ST_STEP;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        parent_d       = parent_q;
        max_gen_d      = max_gen_q;
        gen_count_d    = gen_count_q;
        elite_genome_d = elite_genome_q;
        elite_score_d  = elite_score_q;
        eval_family_d  = eval_family_q;
        wait_cnt_d     = wait_cnt_q;
        win_idx_d      = win_idx_q;
        win_score_d    = win_score_q;
        // Registered valid: high for exactly the cycles spent in OFFER.
        eval_valid_d   = (state_d == ST_OFFER);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    parent_d       = init_parent;
                    max_gen_d      = max_gen;
                    gen_count_d    = '0;
                    elite_genome_d = init_parent;
                    elite_score_d  = '0;
                end
            end
            ST_STEP: wait_cnt_d = WAIT_LOAD;
            ST_WAIT: begin
                if (wait_cnt_q == 16'd0) begin
                    eval_family_d = family;
                end else begin
                    wait_cnt_d = wait_cnt_q - 16'd1;
                end
            end
            ST_SCORE: begin
                if (score_valid) begin
                    win_idx_d   = best_idx;
                    win_score_d = best_score;
                end
            end
            ST_UPDATE: begin
                parent_d    = winner;
                gen_count_d = gen_count_inc;
                if (win_score_q > elite_score_q) begin
                    elite_genome_d = winner;
                    elite_score_d  = win_score_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FINISH);
        lfsr_step = (state_q == ST_STEP);
    end

    assign parent       = parent_q;
    assign eval_valid   = eval_valid_q;
    assign eval_family  = eval_family_q;
    assign gen_count    = gen_count_q;
    assign elite_genome = elite_genome_q;
    assign elite_score  = elite_score_q;

endmodule

// File: tb/tb_generation_controller.sv
module tb_generation_controller;
    import ga_pkg::*;

    localparam logic [31:0] SEED0 = 32'hACE1_2F5B;

    logic                clk = 1'b0;
    logic                rst, start, eval_ready, score_valid;
    logic [GENOME_W-1:0] init_parent, parent, elite_genome;
    logic [15:0]         max_gen, gen_count, elite_score, best_score;
    logic [31:0]         prg_seed;
    logic [FAMILY_W-1:0] family, eval_family;
    logic                eval_valid, busy, done;
    logic [2:0]          best_idx;

    always #5 clk = ~clk;

    generation_controller dut (
        .clk(clk), .rst(rst), .start(start), .init_parent(init_parent),
        .max_gen(max_gen), .prg_seed(prg_seed), .parent(parent), .family(family),
        .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_family(eval_family),
        .score_valid(score_valid), .best_idx(best_idx), .best_score(best_score),
        .busy(busy), .done(done), .gen_count(gen_count),
        .elite_genome(elite_genome), .elite_score(elite_score)
    );

    // Mutation-stage stand-in: genome 0 is the parent, others mix in the seed.
    function automatic logic [GENOME_W-1:0] mutate(input logic [GENOME_W-1:0] p,
                                                   input logic [31:0] s, input int i);
        logic [GENOME_W-1:0] se;
        se = {{(GENOME_W-32){1'b0}}, s};
        if (i == 0) return p;
        return p ^ (se << (i * 29)) ^ GENOME_W'(i);
    endfunction

    function automatic logic [FAMILY_W-1:0] fam_model(input logic [GENOME_W-1:0] p,
                                                      input logic [31:0] s);
        logic [FAMILY_W-1:0] f;
        f = '0;
        for (int i = 0; i < FAMILY_N; i++) f[GENOME_W*(FAMILY_N-i)-1 -: GENOME_W] = mutate(p, s, i);
        return f;
    endfunction

    function automatic logic [GENOME_W-1:0] genome_of(input logic [FAMILY_W-1:0] f, input int i);
        return f[GENOME_W*(FAMILY_N-i)-1 -: GENOME_W];
    endfunction

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        if (n == 32'h0) n = SEED0;
        return n;
    endfunction

    assign family = fam_model(parent, prg_seed);

    typedef struct {
        int          ready_dly;
        logic [2:0]  idx;
        logic [15:0] score;
        bit          early_sv;
        logic [15:0] exp_elite_s;
        int          exp_sel;
    } gen_vec_t;

    gen_vec_t vecs [8];

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int ev_cnt   = 0;
    int busy_cnt = 0;

    logic [31:0]         m_seed;
    logic [GENOME_W-1:0] m_parent, m_elite_g;
    logic [15:0]         m_elite_s, m_gen, m_max;

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (eval_valid) ev_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_fam(input string name, input logic [FAMILY_W-1:0] act,
                           input logic [FAMILY_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [GENOME_W-1:0] ip, input logic [15:0] mg);
        start = 1'b1; init_parent = ip; max_gen = mg;
        tick();
        start = 1'b0; init_parent = ~ip; max_gen = 16'hFFFF;
        m_parent = ip; m_elite_g = ip; m_elite_s = '0; m_gen = '0; m_max = mg;
        chk("busy_after_start", busy, 1'b1);
    endtask

    // Entered with the DUT in STEP; leaves it in STEP or, after the last
    // generation, back in IDLE.
    task automatic run_gen(input gen_vec_t v);
        logic [FAMILY_W-1:0] exp_fam;
        chk("step_seed_held", prg_seed, m_seed);
        chk("step_parent", parent, m_parent);
        tick();
        m_seed = lfsr_model(m_seed);
        chk("wait_seed", prg_seed, m_seed);
        chk("wait_valid_low", eval_valid, 1'b0);
        tick();
        exp_fam = fam_model(m_parent, m_seed);
        chk("offer_valid", eval_valid, 1'b1);
        chk_fam("offer_family", eval_family, exp_fam);
        score_valid = v.early_sv; best_idx = 3'd1; best_score = 16'hFFFF;
        for (int k = 0; k < v.ready_dly; k++) begin
            eval_ready = 1'b0;
            tick();
            chk("offer_hold_valid", eval_valid, 1'b1);
            chk_fam("offer_hold_family", eval_family, exp_fam);
        end
        eval_ready = 1'b1;
        tick();
        eval_ready = 1'b0; score_valid = 1'b0;
        chk("score_valid_dropped", eval_valid, 1'b0);
        tick();
        chk("score_waiting_gen", gen_count, m_gen);
        score_valid = 1'b1; best_idx = v.idx; best_score = v.score;
        tick();
        score_valid = 1'b0; best_idx = 3'd0; best_score = 16'd0;
        tick();
        m_parent = genome_of(exp_fam, v.exp_sel);
        if (v.score > m_elite_s) begin
            m_elite_s = v.score;
            m_elite_g = m_parent;
        end
        m_gen++;
        chk("update_parent", parent, m_parent);
        chk("update_elite_score", elite_score, v.exp_elite_s);
        chk("update_elite_genome", elite_genome, m_elite_g);
        chk("update_gen_count", gen_count, m_gen);
        if (m_gen == m_max) begin
            chk("finish_done", done, 1'b1);
            chk("finish_busy", busy, 1'b1);
            tick();
            chk("idle_done_low", done, 1'b0);
            chk("idle_busy_low", busy, 1'b0);
        end else begin
            chk("mid_done_low", done, 1'b0);
        end
    endtask

    task automatic run_run(input int first, input int n, input logic [15:0] mg,
                           input logic [GENOME_W-1:0] ip);
        done_cnt = 0;
        do_start(ip, mg);
        for (int k = 0; k < n; k++) run_gen(vecs[first + k]);
        chk("done_once", done_cnt, 1);
        chk("seed_after_run", prg_seed, m_seed);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seed"}, prg_seed, SEED0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_parent"}, parent, '0);
        chk_fam({tag, "_eval_family"}, eval_family, '0);
        chk({tag, "_eval_valid"}, eval_valid, 1'b0);
        chk({tag, "_gen_count"}, gen_count, '0);
        chk({tag, "_elite_genome"}, elite_genome, '0);
        chk({tag, "_elite_score"}, elite_score, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 3'd2, 16'd10, 1'b0, 16'd10, 2};
        vecs[1] = '{0, 3'd2, 16'd20, 1'b0, 16'd20, 2};
        vecs[2] = '{0, 3'd2, 16'd15, 1'b0, 16'd20, 2};
        vecs[3] = '{7, 3'd3, 16'd50, 1'b1, 16'd50, 3};
        vecs[4] = '{0, 3'd6, 16'd5,  1'b0, 16'd5,  0};
        vecs[5] = '{2, 3'd4, 16'd5,  1'b1, 16'd5,  4};
        vecs[6] = '{0, 3'd6, 16'd9,  1'b0, 16'd9,  0};
        vecs[7] = '{1, 3'd1, 16'd33, 1'b0, 16'd33, 1};

        rst = 1'b1; start = 1'b0; eval_ready = 1'b0; score_valid = 1'b0;
        best_idx = '0; best_score = '0; init_parent = '0; max_gen = '0;
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        m_seed = SEED0;

        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            init_parent = {5{30'($urandom)}};
            max_gen = 16'($urandom_range(1, 9));
            eval_ready = 1'($urandom); score_valid = 1'($urandom);
            tick();
        end
        eval_ready = 1'b0; score_valid = 1'b0;
        chk("idle_busy_cycles", busy_cnt, 0);
        chk_reset_vals("idle100");

        ev_cnt = 0; busy_cnt = 0; done_cnt = 0;
        do_start({5{30'h2BAD_CAFE}}, 16'd0);
        chk("mg0_done", done, 1'b1);
        chk("mg0_gen_count", gen_count, 16'd0);
        chk("mg0_elite_genome", elite_genome, {5{30'h2BAD_CAFE}});
        tick();
        chk("mg0_idle_busy", busy, 1'b0);
        chk("mg0_busy_cycles", busy_cnt, 1);
        chk("mg0_done_cnt", done_cnt, 1);
        chk("mg0_no_eval_valid", ev_cnt, 0);
        chk("mg0_seed", prg_seed, SEED0);

        run_run(0, 3, 16'd3, {5{30'h1357_9BDF}});
        run_run(3, 1, 16'd1, {5{30'h0F0F_3C3C}});
        run_run(4, 3, 16'd3, {5{30'h3333_5555}});

        do_start({5{30'h1111_2222}}, 16'd2);
        tick(); tick();
        eval_ready = 1'b1;
        tick();
        eval_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("mid_rst");
        m_seed = SEED0;
        run_run(7, 1, 16'd1, {5{30'h2468_ACE0}});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
